// File: rtl/spd_win_mon_pkg.sv
// spd_mon_pkg: shared types and helpers for the spd_win_mon speed monitor.
//   state_t  - window FSM states (IDLE / ACCUM / DONE)
//   trend_t  - per-channel trend code reported on the trend output
//   abs_diff - |a - b| over sign-extended operands, used by the trend and
//              mismatch comparators
package spd_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    FLAT = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    NONE = 2'b11
  } trend_t;

  // Comparators work on operands sign-extended to DIFF_W bits. Any WIDTH up
  // to 31 fits, so the difference here equals the WIDTH+1-bit difference.
  localparam int DIFF_W = 32;

  function automatic logic [DIFF_W-1:0] abs_diff(
    input logic signed [DIFF_W-1:0] a,
    input logic signed [DIFF_W-1:0] b
  );
    logic signed [DIFF_W-1:0] d;
    d = a - b;
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/spd_win_mon_if.sv
// spd_win_mon_if: bundle of the speed-monitor control, sample and result
// signals.
//   master modport - drives start/smpl_en/spd/clr_err, observes results
//   slave  modport - the monitor itself
interface spd_win_mon_if #(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 12
);

  logic                      start;
  logic                      smpl_en;
  logic [NUM_CH*WIDTH-1:0]   spd;
  logic                      clr_err;
  logic [NUM_CH*WIDTH-1:0]   avg;
  logic                      avg_vld;
  logic [NUM_CH*2-1:0]       trend;
  logic                      busy;
  logic                      mis_err;
  logic [NUM_CH-1:0]         mis_ch;

  modport master (
    output start, smpl_en, spd, clr_err,
    input  avg, avg_vld, trend, busy, mis_err, mis_ch
  );

  modport slave (
    input  start, smpl_en, spd, clr_err,
    output avg, avg_vld, trend, busy, mis_err, mis_ch
  );

endinterface

// File: rtl/spd_win_mon_acc_ch.sv
// spd_acc_ch: one speed channel of the window monitor.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - clear the accumulator (window start / restart)
//   add        - accumulate spd this cycle
//   done       - window complete: publish avg/trend, remember avg
//   spd        - signed sample for this channel
//   avg        - floored window average, held until the next completion
//   trend      - FLAT/UP/DOWN against the previous window, NONE if none
module spd_acc_ch
  import spd_mon_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int LOG_WIN   = 10,
  parameter int TREND_TOL = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    add,
  input  logic                    done,
  input  logic signed [WIDTH-1:0] spd,
  output logic signed [WIDTH-1:0] avg,
  output trend_t                  trend
);

  // 2^LOG_WIN samples of WIDTH bits need exactly LOG_WIN extra bits.
  localparam int AW = WIDTH + LOG_WIN;

  logic signed [AW-1:0]     acc;
  logic signed [WIDTH-1:0]  avg_new;
  logic signed [WIDTH-1:0]  prev_avg;
  logic                     prev_vld;
  logic signed [DIFF_W-1:0] avg_new_x;
  logic signed [DIFF_W-1:0] prev_x;
  logic signed [DIFF_W-1:0] d;
  trend_t                   trend_new;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    // Arithmetic shift floors toward -inf; the quotient always fits WIDTH.
    avg_new   = WIDTH'(acc >>> LOG_WIN);
    avg_new_x = DIFF_W'(avg_new);
    prev_x    = DIFF_W'(prev_avg);
    d         = avg_new_x - prev_x;
    trend_new = NONE;
    if (prev_vld) begin
      if (abs_diff(avg_new_x, prev_x) <= DIFF_W'(TREND_TOL)) trend_new = FLAT;
      else if (d > 0)                                        trend_new = UP;
      else                                                   trend_new = DOWN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  // NOTE: the accumulator is reset too, so a reset mid-window discards partial sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      avg      <= '0;
      prev_avg <= '0;
      prev_vld <= 1'b0;
      trend    <= NONE;
    end else begin
      if (clr)      acc <= '0;
      else if (add) acc <= acc + AW'(spd);

      // done reads the finished sum; a simultaneous clr only affects the next window.
      if (done) begin
        avg      <= avg_new;
        trend    <= trend_new;
        prev_avg <= avg_new;
        prev_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spd_win_mon.sv
// spd_win_mon: multi-channel windowed speed monitor.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - spd_win_mon_if slave:
//     start    - begin / restart a window
//     smpl_en  - sample qualifier
//     spd      - packed signed samples, channel i at [i*WIDTH +: WIDTH]
//     clr_err  - clear the sticky mismatch flag
//     avg      - packed window averages, held until the next completion
//     avg_vld  - one-cycle pulse when avg/trend update
//     trend    - 2 bits per channel (00 flat, 01 up, 10 down, 11 none)
//     busy     - window accumulating
//     mis_err  - sticky mismatch flag
//     mis_ch   - registered per-channel mismatch vs channel 0 (bit 0 = 0)
module spd_win_mon
  import spd_mon_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int WIDTH     = 12,
  parameter int LOG_WIN   = 10,
  parameter int MATCH_TOL = 10,
  parameter int TREND_TOL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  spd_win_mon_if.slave bus
);

  state_t               state;
  state_t               state_nxt;
  logic [LOG_WIN-1:0]   cnt;
  logic                 clr;
  logic                 add;
  logic                 done;
  logic                 avg_vld_q;
  logic [NUM_CH-1:0]    mis_nxt;
  logic [NUM_CH-1:0]    mis_ch_q;
  logic                 mis_err_q;

  logic signed [WIDTH-1:0] spd_ch [NUM_CH];
  logic signed [WIDTH-1:0] avg_ch [NUM_CH];
  trend_t                  trend_ch [NUM_CH];

  // Window FSM. start always wins in ACCUM (restart, sample discarded) and
  // is honoured in DONE so back-to-back windows lose no cycle.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    add       = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          clr       = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.start) begin
          clr = 1'b1;
        end else if (bus.smpl_en) begin
          add = 1'b1;
          // cnt holds samples already taken; all-ones means this is the last.
          if (cnt == '1) state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          clr       = 1'b1;
          state_nxt = ACCUM;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      avg_vld_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      avg_vld_q <= done;
      // The counter wraps to zero on the final sample of a window.
      if (clr)      cnt <= '0;
      else if (add) cnt <= cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign spd_ch[i] = bus.spd[i*WIDTH +: WIDTH];

    spd_acc_ch #(
      .WIDTH     (WIDTH),
      .LOG_WIN   (LOG_WIN),
      .TREND_TOL (TREND_TOL)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .add   (add),
      .done  (done),
      .spd   (spd_ch[i]),
      .avg   (avg_ch[i]),
      .trend (trend_ch[i])
    );

    assign bus.avg[i*WIDTH +: WIDTH] = avg_ch[i];
    assign bus.trend[2*i +: 2]       = trend_ch[i];
  end

  // Mismatch against channel 0, independent of the window FSM.
  always_comb begin
    mis_nxt = '0;
    for (int i = 1; i < NUM_CH; i++) begin
      mis_nxt[i] = abs_diff(DIFF_W'(spd_ch[i]), DIFF_W'(spd_ch[0])) > DIFF_W'(MATCH_TOL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_ch_q  <= '0;
      mis_err_q <= 1'b0;
    end else begin
      if (bus.smpl_en) mis_ch_q <= mis_nxt;
      // Set has priority over clear so a live mismatch is never lost.
      if (|mis_ch_q)        mis_err_q <= 1'b1;
      else if (bus.clr_err) mis_err_q <= 1'b0;
    end
  end

  assign bus.avg_vld = avg_vld_q;
  assign bus.busy    = (state == ACCUM);
  assign bus.mis_ch  = mis_ch_q;
  assign bus.mis_err = mis_err_q;

endmodule

// File: tb/tb_spd_win_mon.sv
module tb_spd_win_mon;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spd_win_mon_if #(.NUM_CH(2), .WIDTH(12)) bus ();
  spd_win_mon_if #(.NUM_CH(4), .WIDTH(16)) bus_w ();

  spd_win_mon u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  spd_win_mon #(
    .NUM_CH  (4),
    .WIDTH   (16),
    .LOG_WIN (4)
  ) u_dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w.slave)
  );

  typedef struct {
    logic [63:0] avg;
    logic [63:0] trend;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t sb_w[$];
  int   start_cyc;
  int   start_cyc_w;

  // Reference model state for trend prediction.
  longint prev;
  bit     prev_vld;
  longint prev_w [4];
  bit     prev_vld_w;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint floor_div(input longint s, input longint dv);
    longint q;
    q = s / dv;
    if ((s % dv != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [1:0] trend_of(input bit pv, input longint p, input longint a);
    longint dd;
    if (!pv) return 2'b11;
    dd = a - p;
    if ((dd <= 4) && (dd >= -4)) return 2'b00;
    if (dd > 0) return 2'b01;
    return 2'b10;
  endfunction

  // Scoreboard consumers: compare on every avg_vld pulse, away from the edge.
  always @(negedge clk) begin
    if (bus.avg_vld) begin
      if (sb.size() == 0) begin
        check("vld_unexp", 64'(bus.avg_vld), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("avg", 64'(bus.avg), e.avg);
        check("trend", 64'(bus.trend), e.trend);
        check("latency", 64'(cyc - start_cyc), 64'(e.lat));
      end
    end
    if (bus_w.avg_vld) begin
      if (sb_w.size() == 0) begin
        check("vld_unexp_w", 64'(bus_w.avg_vld), 64'd0);
      end else begin
        exp_t e;
        e = sb_w.pop_front();
        check("avg_w", 64'(bus_w.avg), e.avg);
        check("trend_w", 64'(bus_w.trend), e.trend);
        check("latency_w", 64'(cyc - start_cyc_w), 64'(e.lat));
      end
    end
  end

  // One window on the 2-channel monitor; both channels carry a on even
  // samples and b on odd ones. With restart_at > 0, pre_val is driven until
  // that many samples are taken, then start restarts the window.
  task automatic run_win(input int a, input int b, input bit tog,
                         input int restart_at, input int pre_val);
    longint sum;
    longint q;
    int     n;
    int     i;
    int     v;
    bit     pre;
    logic [1:0] t;
    exp_t   e;
    pre = (restart_at > 0);
    bus.start   = 1'b1;
    bus.smpl_en = 1'b0;
    start_cyc   = cyc + 1;
    tick();
    bus.start = 1'b0;
    check("busy_hi", 64'(bus.busy), 64'd1);
    sum = 0; n = 0; i = 0;
    while (n < 1024) begin
      if (pre && n == restart_at) begin
        bus.start   = 1'b1;
        bus.smpl_en = 1'b1;
        start_cyc   = cyc + 1;
        tick();
        bus.start = 1'b0;
        check("busy_restart", 64'(bus.busy), 64'd1);
        sum = 0; n = 0; i = 0; pre = 1'b0;
        continue;
      end
      bus.smpl_en = tog ? (i % 2 == 0) : 1'b1;
      v = pre ? pre_val : ((n % 2 == 0) ? a : b);
      bus.spd = {12'(v), 12'(v)};
      if (bus.smpl_en) begin
        sum += v;
        n++;
      end
      i++;
      tick();
    end
    bus.smpl_en = 1'b0;
    q = floor_div(sum, 1024);
    t = trend_of(prev_vld, prev, q);
    prev = q;
    prev_vld = 1'b1;
    e.avg   = {40'd0, 12'(q), 12'(q)};
    e.trend = {60'd0, t, t};
    e.lat   = tog ? 2048 : 1025;
    sb.push_back(e);
    for (int k = 0; k < 8 && sb.size() != 0; k++) tick();
    check("vld_seen", 64'(sb.size()), 64'd0);
    sb.delete();
    check("busy_lo", 64'(bus.busy), 64'd0);
    check("vld_pulse", 64'(bus.avg_vld), 64'd0);
    check("avg_hold", 64'(bus.avg), e.avg);
  endtask

  // One 16-sample window on the 4-channel, 16-bit monitor at full scale.
  task automatic run_small();
    longint s [4];
    int     v [4];
    longint q;
    exp_t   e;
    bus_w.start   = 1'b1;
    bus_w.smpl_en = 1'b0;
    start_cyc_w   = cyc + 1;
    tick();
    bus_w.start = 1'b0;
    for (int c = 0; c < 4; c++) s[c] = 0;
    for (int n = 0; n < 16; n++) begin
      v[0] = 32767;
      v[1] = -32767;
      v[2] = (n % 2 != 0) ? -32767 : 32767;
      v[3] = (n == 5) ? -32767 : 32767;
      bus_w.spd     = {16'(v[3]), 16'(v[2]), 16'(v[1]), 16'(v[0])};
      bus_w.smpl_en = 1'b1;
      for (int c = 0; c < 4; c++) s[c] += v[c];
      tick();
    end
    bus_w.smpl_en = 1'b0;
    e.avg = '0;
    e.trend = '0;
    for (int c = 0; c < 4; c++) begin
      q = floor_div(s[c], 16);
      e.avg[c*16 +: 16]  = 16'(q);
      e.trend[c*2 +: 2]  = trend_of(prev_vld_w, prev_w[c], q);
      prev_w[c] = q;
    end
    prev_vld_w = 1'b1;
    e.lat = 17;
    sb_w.push_back(e);
    for (int k = 0; k < 8 && sb_w.size() != 0; k++) tick();
    check("vld_seen_w", 64'(sb_w.size()), 64'd0);
    sb_w.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.smpl_en = 1'b0; bus.spd = '0; bus.clr_err = 1'b0;
    bus_w.start = 1'b0; bus_w.smpl_en = 1'b0; bus_w.spd = '0; bus_w.clr_err = 1'b0;
    prev = 0; prev_vld = 1'b0; prev_vld_w = 1'b0;
    for (int c = 0; c < 4; c++) prev_w[c] = 0;
    tick();
    tick();
    check("rst_avg", 64'(bus.avg), 64'd0);
    check("rst_vld", 64'(bus.avg_vld), 64'd0);
    check("rst_trend", 64'(bus.trend), 64'hF);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_mis_err", 64'(bus.mis_err), 64'd0);
    check("rst_mis_ch", 64'(bus.mis_ch), 64'd0);
    rst_n = 1'b1;
    tick();

    // Trend sequence: none, flat, up, down, then the floored -5/-6 window.
    run_win(300, 300, 1'b0, 0, 0);
    run_win(300, 300, 1'b0, 0, 0);
    run_win(400, 400, 1'b0, 0, 0);
    run_win(-50, -50, 1'b0, 0, 0);
    run_win(-5, -6, 1'b0, 0, 0);

    // Mismatch tolerance boundary, sticky flag, set-over-clear priority.
    bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
    bus.smpl_en = 1'b1;
    bus.spd = {12'd110, 12'd100};
    tick();
    check("mis_110", 64'(bus.mis_ch), 64'd0);
    tick();
    check("mis_err_110", 64'(bus.mis_err), 64'd0);
    bus.spd = {12'd111, 12'd100};
    tick();
    check("mis_111", 64'(bus.mis_ch), 64'd2);
    check("mis_err_lag", 64'(bus.mis_err), 64'd0);
    tick();
    check("mis_err_set", 64'(bus.mis_err), 64'd1);
    bus.clr_err = 1'b1;
    tick();
    check("mis_err_clr_held", 64'(bus.mis_err), 64'd1);
    bus.clr_err = 1'b0;
    bus.spd = {12'd100, 12'd100};
    tick();
    check("mis_gone", 64'(bus.mis_ch), 64'd0);
    bus.smpl_en = 1'b0;
    bus.clr_err = 1'b1;
    tick();
    check("mis_err_clr", 64'(bus.mis_err), 64'd0);
    bus.clr_err = 1'b0;
    bus.smpl_en = 1'b1;
    bus.spd = {12'd89, 12'd100};
    tick();
    check("mis_neg", 64'(bus.mis_ch), 64'd2);
    bus.spd = {12'd90, 12'd100};
    tick();
    check("mis_neg_edge", 64'(bus.mis_ch), 64'd0);
    bus.smpl_en = 1'b0;
    bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;

    // Reset in the middle of a window with a live mismatch.
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.smpl_en = 1'b1;
    bus.spd = {12'd200, 12'd100};
    repeat (300) tick();
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    check("pre_rst_mis_err", 64'(bus.mis_err), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_avg", 64'(bus.avg), 64'd0);
    check("mid_rst_trend", 64'(bus.trend), 64'hF);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_mis_err", 64'(bus.mis_err), 64'd0);
    check("mid_rst_mis_ch", 64'(bus.mis_ch), 64'd0);
    check("mid_rst_vld", 64'(bus.avg_vld), 64'd0);
    prev_vld = 1'b0;
    prev_vld_w = 1'b0;
    bus.smpl_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Half-rate sampling with a restart after 500 samples; first window after reset.
    run_win(77, 77, 1'b1, 500, 1000);

    // Wide configuration: full-scale inputs, no overflow, then a flat repeat.
    run_small();
    run_small();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
